// File: rtl/tcore_xgmii_pkg.sv
// -----------------------------------------------------------------------------
// tcore_xgmii_pkg
// Shared definitions for the XGMII transmit path.
//   - XGMII control character codes and whole-word constants
//   - framer state enum
//   - saturating inter-packet-gap counter helper
// -----------------------------------------------------------------------------
package tcore_xgmii_pkg;

    // XGMII control characters (valid only where the matching txc bit is 1)
    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERR   = 8'hFE;
    localparam logic [7:0] CH_SEQ   = 8'h9C;

    // Start character in lane 0 followed by preamble and SFD in lanes 1..7
    localparam logic [63:0] PREAMBLE_WORD = {8'hD5, {6{8'h55}}, CH_START};
    localparam logic [7:0]  PREAMBLE_TXC  = 8'h01;

    localparam logic [63:0] IDLE_WORD = {8{CH_IDLE}};
    localparam logic [7:0]  IDLE_TXC  = 8'hFF;

    localparam int          IPG_CNT_W   = 7;
    localparam logic [6:0]  IPG_CNT_MAX = 7'd127;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_TERM,
        ST_IPG,
        ST_DROP
    } tx_state_e;

    // Eight more idle bytes on the wire, clamped so the counter never wraps
    // back below the gap threshold during a long idle stretch.
    function automatic logic [IPG_CNT_W-1:0] ipg_add8(input logic [IPG_CNT_W-1:0] cnt);
        logic [IPG_CNT_W:0] sum;
        sum = {1'b0, cnt} + 8'd8;
        return sum[IPG_CNT_W] ? IPG_CNT_MAX : sum[IPG_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/tcore_xgmii_term_gen.sv
// -----------------------------------------------------------------------------
// tcore_xgmii_term_gen
// Builds the XGMII terminate word for an end-of-frame data word.
//   data_i  : frame bytes, lane 0 = bits 7:0
//   bcnt_i  : number of data lanes n (0..7); lane n carries /T/,
//             lanes above n carry /I/. n=0 yields a pure /T/ word.
//   err_i   : replace lane 0 with /E/ (abort word when used with n=1)
//   txd_o   : XGMII data
//   txc_o   : XGMII control mask, 1 = control character
// -----------------------------------------------------------------------------
module tcore_xgmii_term_gen
    import tcore_xgmii_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  bcnt_i,
    input  logic        err_i,
    output logic [63:0] txd_o,
    output logic [7:0]  txc_o
);

    for (genvar l = 0; l < 8; l++) begin : g_lane
        logic [7:0] lane_byte;
        logic       lane_ctl;

        always_comb begin
            lane_byte = CH_IDLE;
            lane_ctl  = 1'b1;
            if (err_i && (l == 0)) begin
                lane_byte = CH_ERR;
            end else if (3'(l) < bcnt_i) begin
                lane_byte = data_i[8*l +: 8];
                lane_ctl  = 1'b0;
            end else if (3'(l) == bcnt_i) begin
                lane_byte = CH_TERM;
            end
        end

        assign txd_o[8*l +: 8] = lane_byte;
        assign txc_o[l]        = lane_ctl;
    end

endmodule

// File: rtl/tcore_xgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// tcore_xgmii_tx_framer
// Transmit-side XGMII framer. Wraps MAC TX frames (64-bit words, no
// preamble) into a lane-0-aligned XGMII stream: start/preamble word, data,
// terminate, idles. Enforces a minimum inter-packet gap and aborts frames
// with /E/ on underrun, link loss or TX disable.
//
// Parameters
//   IPG_BYTES    minimum idle bytes between frames, counted from the /T/
//                lane inclusive (8..64)
// Ports
//   xaui_clk     156.25 MHz transmit clock
//   reset        synchronous active-high reset
//   fmac_txd_en  TX enable; low clears counters, forces idle
//   linkup       link-good from the receive side
//   tx_data      frame bytes, lane 0 = bits 7:0 = first on wire
//   tx_valid     tx_data valid
//   tx_sof       first word of frame
//   tx_eof       last word of frame
//   tx_bcnt      valid bytes in eof word, 0 = 8
//   tx_ready     word accepted when tx_valid & tx_ready (combinational)
//   xgmii_txd    registered XGMII data
//   xgmii_txc    registered XGMII control
//   TX_FRAME_CNT frames completed without error
//   TX_ERR_CNT   aborted frames plus stray words
// -----------------------------------------------------------------------------
module tcore_xgmii_tx_framer
    import tcore_xgmii_pkg::*;
#(
    parameter int IPG_BYTES = 12
) (
    input  logic        xaui_clk,
    input  logic        reset,
    input  logic        fmac_txd_en,
    input  logic        linkup,
    input  logic [63:0] tx_data,
    input  logic        tx_valid,
    input  logic        tx_sof,
    input  logic        tx_eof,
    input  logic [2:0]  tx_bcnt,
    output logic        tx_ready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [31:0] TX_FRAME_CNT,
    output logic [31:0] TX_ERR_CNT
);

    localparam logic [IPG_CNT_W-1:0] IPG_MIN = IPG_CNT_W'(IPG_BYTES);

    tx_state_e              state_q, state_d;
    logic [IPG_CNT_W-1:0]   ipg_cnt_q, ipg_cnt_d;
    logic [63:0]            txd_q, txd_d;
    logic [7:0]             txc_q, txc_d;
    logic [31:0]            frame_cnt_q, err_cnt_q;

    logic                   ready_c;
    logic                   frame_inc;
    logic                   err_inc;

    // DATA-state abort causes; an accepted eof on the aborting word means
    // nothing is left to drain.
    logic abort;
    logic eof_acc;
    logic is_abort;
    logic start_ok;
    logic ipg_done;

    assign abort    = !tx_valid || !linkup || !fmac_txd_en;
    assign eof_acc  = tx_valid && tx_eof;
    assign is_abort = (state_q == ST_DATA) && abort;
    assign start_ok = tx_valid && tx_sof && linkup && fmac_txd_en &&
                      (ipg_cnt_q >= IPG_MIN);
    assign ipg_done = ({1'b0, ipg_cnt_q} + 8'd8) >= {1'b0, IPG_MIN};

    // One terminate generator serves three words: the partial eof word
    // (n = tx_bcnt), the standalone /T/ word (n = 0) and the abort word
    // (n = 1 with lane 0 overridden to /E/).
    logic [2:0]  tg_bcnt;
    logic        tg_err;
    logic [63:0] tg_txd;
    logic [7:0]  tg_txc;

    assign tg_bcnt = (state_q == ST_TERM) ? 3'd0 :
                     is_abort             ? 3'd1 : tx_bcnt;
    assign tg_err  = is_abort;

    tcore_xgmii_term_gen u_term_gen (
        .data_i (tx_data),
        .bcnt_i (tg_bcnt),
        .err_i  (tg_err),
        .txd_o  (tg_txd),
        .txc_o  (tg_txc)
    );

    // -------------------------------------------------------------------------
    // Next-state / output decision
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ipg_cnt_d = ipg_cnt_q;
        txd_d     = IDLE_WORD;
        txc_d     = IDLE_TXC;
        ready_c   = 1'b0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Idles on the wire still count toward the gap; this also
                // lets a disable-time abort recover without visiting IPG.
                ipg_cnt_d = ipg_add8(ipg_cnt_q);
                if (tx_valid && !tx_sof) begin
                    ready_c = 1'b1;
                    err_inc = 1'b1;
                end else if (start_ok) begin
                    // sof word stays on the input; DATA consumes it next cycle
                    txd_d   = PREAMBLE_WORD;
                    txc_d   = PREAMBLE_TXC;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                ready_c = 1'b1;
                if (abort) begin
                    txd_d     = tg_txd;
                    txc_d     = tg_txc;
                    err_inc   = 1'b1;
                    ipg_cnt_d = 7'd7;
                    if (!fmac_txd_en) begin
                        state_d = ST_IDLE;
                    end else if (eof_acc) begin
                        state_d = ST_IPG;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (tx_eof && (tx_bcnt == 3'd0)) begin
                    // full eof word: /T/ goes out alone in the next word
                    txd_d   = tx_data;
                    txc_d   = 8'h00;
                    state_d = ST_TERM;
                end else if (tx_eof) begin
                    txd_d     = tg_txd;
                    txc_d     = tg_txc;
                    ipg_cnt_d = 7'd8 - {4'd0, tx_bcnt};
                    frame_inc = 1'b1;
                    state_d   = ST_IPG;
                end else begin
                    txd_d = tx_data;
                    txc_d = 8'h00;
                end
            end

            ST_TERM: begin
                txd_d     = tg_txd;
                txc_d     = tg_txc;
                ipg_cnt_d = 7'd8;
                frame_inc = 1'b1;
                state_d   = ST_IPG;
            end

            ST_IPG: begin
                ipg_cnt_d = ipg_add8(ipg_cnt_q);
                if (ipg_done) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DROP: begin
                ready_c   = 1'b1;
                ipg_cnt_d = ipg_add8(ipg_cnt_q);
                if (eof_acc) begin
                    state_d = ST_IPG;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // TX disable: DATA has already taken the abort path above; every
        // other state drops straight back to idle output.
        if (!fmac_txd_en && (state_q != ST_DATA)) begin
            state_d   = ST_IDLE;
            txd_d     = IDLE_WORD;
            txc_d     = IDLE_TXC;
            frame_inc = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge xaui_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ipg_cnt_q <= IPG_MIN;
            txd_q     <= IDLE_WORD;
            txc_q     <= IDLE_TXC;
        end else begin
            state_q   <= state_d;
            ipg_cnt_q <= ipg_cnt_d;
            txd_q     <= txd_d;
            txc_q     <= txc_d;
        end
    end

    always_ff @(posedge xaui_clk) begin
        if (reset || !fmac_txd_en) begin
            frame_cnt_q <= 32'd0;
            err_cnt_q   <= 32'd0;
        end else begin
            if (frame_inc) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (err_inc) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign tx_ready     = ready_c;
    assign xgmii_txd    = txd_q;
    assign xgmii_txc    = txc_q;
    assign TX_FRAME_CNT = frame_cnt_q;
    assign TX_ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_tcore_xgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_tcore_xgmii_tx_framer
// Self-checking bench for tcore_xgmii_tx_framer. Frames are described as byte
// arrays; the expected XGMII word stream and counter values are derived from
// the byte counts, and the observed non-idle stream plus idle gaps are
// compared against it.
// -----------------------------------------------------------------------------
module tb_tcore_xgmii_tx_framer;

    localparam int IPG = 12;
    localparam logic [71:0] W_PRE   = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] W_ABORT = {8'hFF, 64'h070707070707FDFE};
    localparam logic [71:0] W_TERM  = {8'hFF, 64'h07070707070707FD};
    localparam logic [71:0] W_IDLE  = {8'hFF, 64'h0707070707070707};

    logic        xaui_clk = 1'b0;
    logic        reset = 1'b1;
    logic        fmac_txd_en = 1'b1;
    logic        linkup = 1'b1;
    logic [63:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_sof = 1'b0;
    logic        tx_eof = 1'b0;
    logic [2:0]  tx_bcnt = '0;
    logic        tx_ready;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [31:0] TX_FRAME_CNT;
    logic [31:0] TX_ERR_CNT;

    tcore_xgmii_tx_framer #(.IPG_BYTES(IPG)) dut (
        .xaui_clk     (xaui_clk),
        .reset        (reset),
        .fmac_txd_en  (fmac_txd_en),
        .linkup       (linkup),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_sof       (tx_sof),
        .tx_eof       (tx_eof),
        .tx_bcnt      (tx_bcnt),
        .tx_ready     (tx_ready),
        .xgmii_txd    (xgmii_txd),
        .xgmii_txc    (xgmii_txc),
        .TX_FRAME_CNT (TX_FRAME_CNT),
        .TX_ERR_CNT   (TX_ERR_CNT)
    );

    always #5 xaui_clk = ~xaui_clk;

    typedef struct {
        logic [63:0] d;
        logic        sof;
        logic        eof;
        logic [2:0]  bcnt;
        int          gap;
        logic        link;
    } wd_t;

    wd_t         drv_q[$];
    logic [71:0] exp_q[$];
    logic [71:0] obs_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          exp_frames = 0;
    int          exp_errs = 0;
    bit          gap_exact = 1'b0;
    int          last_fd = -1;
    int          idles = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor: collect every non-idle word; measure idle gap from the word
    // carrying /T/ to the next preamble.
    // ---------------------------------------------------------------------
    always @(negedge xaui_clk) begin
        if (reset) begin
            last_fd = -1;
            idles   = 0;
        end else if ({xgmii_txc, xgmii_txd} == W_IDLE) begin
            idles++;
        end else begin
            if ({xgmii_txc, xgmii_txd} == W_PRE) begin
                if (last_fd >= 0) begin
                    int e;
                    e = (IPG - (8 - last_fd) + 7) / 8;
                    if (e < 1) e = 1;
                    if (gap_exact) chk("gap_exact", 72'(idles), 72'(e));
                    else           chk("gap_min", 72'(idles >= e), 72'd1);
                end
                last_fd = -1;
            end else if (xgmii_txc[0] && xgmii_txd[7:0] == 8'hFE) begin
                last_fd = -1;
            end else begin
                last_fd = -1;
                for (int l = 0; l < 8; l++)
                    if (last_fd < 0 && xgmii_txc[l] && xgmii_txd[8*l +: 8] == 8'hFD)
                        last_fd = l;
            end
            idles = 0;
            obs_q.push_back({xgmii_txc, xgmii_txd});
        end
    end

    // ---------------------------------------------------------------------
    // Reference: frame of len bytes -> XGMII words. brk >= 0 means the frame
    // is cut after brk data words and an abort word replaces the rest.
    // ---------------------------------------------------------------------
    function automatic void add_expected(input logic [7:0] b[$], input int brk);
        int nw;
        exp_q.push_back(W_PRE);
        nw = (b.size() + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            logic [63:0] txd;
            logic [7:0]  txc;
            int          nb;
            if (w == brk) begin
                exp_q.push_back(W_ABORT);
                return;
            end
            nb = (w == nw - 1) ? b.size() - 8 * w : 8;
            for (int l = 0; l < 8; l++) begin
                if (l < nb)       begin txd[8*l +: 8] = b[8*w + l]; txc[l] = 1'b0; end
                else if (l == nb) begin txd[8*l +: 8] = 8'hFD;      txc[l] = 1'b1; end
                else              begin txd[8*l +: 8] = 8'h07;      txc[l] = 1'b1; end
            end
            exp_q.push_back({txc, txd});
            if (w == nw - 1 && nb == 8) exp_q.push_back(W_TERM);
        end
    endfunction

    // mode 0: underrun (valid low 2 cycles) before word brk; mode 1: link
    // drops from word brk onward. brk < 0: clean frame.
    task automatic queue_frame(input int len, input int sgap, input int brk, input int mode);
        logic [7:0] b[$];
        int nw;
        for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        nw = (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            wd_t wd;
            int  nb;
            nb = (w == nw - 1) ? len - 8 * w : 8;
            for (int l = 0; l < 8; l++) wd.d[8*l +: 8] = (l < nb) ? b[8*w + l] : 8'($urandom);
            wd.sof  = (w == 0);
            wd.eof  = (w == nw - 1);
            wd.bcnt = 3'(nb % 8);
            wd.gap  = (w == 0) ? sgap : ((mode == 0 && w == brk) ? 2 : 0);
            wd.link = !(mode == 1 && brk >= 0 && w >= brk);
            drv_q.push_back(wd);
        end
        add_expected(b, brk);
        if (brk < 0) exp_frames++;
        else         exp_errs++;
    endtask

    task automatic run_drv(input int budget);
        int cyc = 0;
        while (drv_q.size() > 0 && cyc < budget) begin
            wd_t w;
            bit  acc;
            w = drv_q.pop_front();
            for (int g = 0; g < w.gap; g++) begin
                @(negedge xaui_clk);
                tx_valid = 1'b0;
                linkup   = w.link;
                cyc++;
            end
            acc = 1'b0;
            while (!acc && cyc < budget) begin
                @(negedge xaui_clk);
                tx_valid = 1'b1; tx_data = w.d; tx_sof = w.sof;
                tx_eof = w.eof; tx_bcnt = w.bcnt; linkup = w.link;
                #1;
                acc = tx_ready;
                cyc++;
            end
        end
        chk("drv_budget", 72'(cyc < budget), 72'd1);
        @(negedge xaui_clk);
        tx_valid = 1'b0; tx_sof = 1'b0; tx_eof = 1'b0; linkup = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge xaui_clk);
    endtask

    task automatic do_reset();
        @(negedge xaui_clk);
        reset = 1'b1; tx_valid = 1'b0; linkup = 1'b1; fmac_txd_en = 1'b1;
        idle_cycles(2);
        obs_q.delete(); exp_q.delete(); drv_q.delete();
        exp_frames = 0; exp_errs = 0;
        reset = 1'b0;
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 72'(obs_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_frames"}, 72'(TX_FRAME_CNT), 72'(exp_frames));
        chk({tag, "_errs"},   72'(TX_ERR_CNT),   72'(exp_errs));
    endtask

    initial begin
        // reset state
        idle_cycles(3);
        chk("rst_txd", 72'(xgmii_txd), 72'h0707070707070707);
        chk("rst_txc", 72'(xgmii_txc), 72'hFF);
        chk("rst_frames", 72'(TX_FRAME_CNT), 72'd0);
        chk("rst_errs", 72'(TX_ERR_CNT), 72'd0);
        do_reset();
        chk("idle_ready", 72'(tx_ready), 72'd0);

        // back-to-back 64B, 61B, 16B: exact minimum gaps
        gap_exact = 1'b1;
        queue_frame(64, 0, -1, 0);
        queue_frame(61, 0, -1, 0);
        queue_frame(16, 0, -1, 0);
        run_drv(500);
        idle_cycles(8);
        cmp_stream("b2b");
        chk_cnts("b2b");
        gap_exact = 1'b0;

        // underrun after 3 data words
        do_reset();
        queue_frame(48, 0, 3, 0);
        run_drv(500);
        idle_cycles(8);
        cmp_stream("urun");
        chk_cnts("urun");

        // stray word in IDLE
        do_reset();
        @(negedge xaui_clk);
        tx_valid = 1'b1; tx_sof = 1'b0; tx_eof = 1'b0; tx_data = 64'h1122334455667788;
        #1 chk("stray_ready", 72'(tx_ready), 72'd1);
        @(negedge xaui_clk);
        tx_valid = 1'b0;
        chk("stray_out", {xgmii_txc, xgmii_txd}, W_IDLE);
        chk("stray_errs", 72'(TX_ERR_CNT), 72'd1);

        // link loss mid-frame, then sof refused while link is down
        do_reset();
        queue_frame(32, 0, 2, 1);
        run_drv(500);
        linkup = 1'b0;
        idle_cycles(6);
        cmp_stream("link");
        for (int i = 0; i < 4; i++) begin
            @(negedge xaui_clk);
            tx_valid = 1'b1; tx_sof = 1'b1; tx_eof = 1'b0;
            #1 chk($sformatf("link_ready%0d", i), 72'(tx_ready), 72'd0);
        end
        chk("link_out", {xgmii_txc, xgmii_txd}, W_IDLE);
        chk_cnts("link");
        @(negedge xaui_clk);
        tx_valid = 1'b0; tx_sof = 1'b0; linkup = 1'b1;

        // reset mid-frame, then TX disable clears counters
        do_reset();
        queue_frame(16, 0, -1, 0);
        run_drv(200);
        idle_cycles(4);
        chk("mid_pre_frames", 72'(TX_FRAME_CNT), 72'd1);
        @(negedge xaui_clk);
        tx_valid = 1'b1; tx_sof = 1'b1; tx_eof = 1'b0; tx_data = 64'hA5A5A5A5A5A5A5A5;
        idle_cycles(2);
        tx_sof = 1'b0;
        reset = 1'b1;
        @(negedge xaui_clk);
        chk("mid_rst_out", {xgmii_txc, xgmii_txd}, W_IDLE);
        chk("mid_rst_frames", 72'(TX_FRAME_CNT), 72'd0);
        reset = 1'b0; tx_valid = 1'b1;
        @(negedge xaui_clk);
        tx_valid = 1'b0;
        chk("mid_stray_errs", 72'(TX_ERR_CNT), 72'd1);
        fmac_txd_en = 1'b0;
        @(negedge xaui_clk);
        chk("dis_out", {xgmii_txc, xgmii_txd}, W_IDLE);
        chk("dis_frames", 72'(TX_FRAME_CNT), 72'd0);
        chk("dis_errs", 72'(TX_ERR_CNT), 72'd0);
        fmac_txd_en = 1'b1;

        // randomized frames with occasional underrun / link loss
        do_reset();
        for (int f = 0; f < 25; f++) begin
            int len, nw, brk, mode;
            len  = $urandom_range(1, 40);
            nw   = (len + 7) / 8;
            brk  = -1;
            mode = 0;
            if (nw >= 3 && $urandom_range(0, 4) == 0) begin
                brk  = $urandom_range(1, nw - 2);
                mode = $urandom_range(0, 1);
            end
            queue_frame(len, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, brk, mode);
        end
        run_drv(5000);
        idle_cycles(8);
        cmp_stream("rnd");
        chk_cnts("rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
